// File: rtl/fft_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_seq                                                   |
// | Brief    : memory-based radix-2 DIT FFT, one shared butterfly,       |
// |            valid/ready load and unload, external twiddle ROM port    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fft_seq #(
    parameter int DBW   = 8,
    parameter int LOG2N = 3,
    parameter int TBW   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      inverse,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DBW-1:0]     din_re,
    input  logic signed [DBW-1:0]     din_im,
    output logic [LOG2N-2:0]          tw_addr,
    input  logic signed [TBW-1:0]     tw_re,
    input  logic signed [TBW-1:0]     tw_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DBW+LOG2N:0] dout_re,
    output logic signed [DBW+LOG2N:0] dout_im,
    output logic                      out_last,
    output logic                      busy
);

    localparam int c_N  = 1 << LOG2N;
    localparam int c_W  = DBW + LOG2N + 1;
    localparam int c_SW = $clog2(LOG2N + 1);
    localparam int c_PW = c_W + TBW + 2;

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_CALC   = 2'd1;
    localparam logic [1:0] c_ST_UNLOAD = 2'd2;

    localparam logic [LOG2N-1:0] c_CNT_LAST   = '1;
    localparam logic [LOG2N-1:0] c_ONE        = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-2:0] c_BF_ONES    = '1;
    localparam logic [c_SW-1:0]  c_STAGE_LAST = c_SW'(LOG2N - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [LOG2N-1:0]        r_load_cnt;
    logic [LOG2N-1:0]        r_out_cnt;
    logic [LOG2N-2:0]        r_bfly;
    logic [c_SW-1:0]         r_stage;
    logic                    r_exec;
    logic                    r_inv;
    logic signed [c_W-1:0]   r_mem_re [c_N];
    logic signed [c_W-1:0]   r_mem_im [c_N];

    logic                    w_abort;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_exec;
    logic                    w_calc_last;

    logic [LOG2N-2:0]        w_k;
    logic [LOG2N-1:0]        w_top;
    logic [LOG2N-1:0]        w_bot;
    logic [LOG2N-1:0]        w_half;
    logic [c_SW-1:0]         w_tw_sh;
    logic [LOG2N-2:0]        w_tw_addr;

    logic signed [c_W-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [c_PW-1:0]  w_br, w_bi, w_wr, w_wi_raw, w_wi;
    logic signed [c_PW-1:0]  w_pr, w_pi;
    logic signed [c_W-1:0]   w_t_re, w_t_im;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] v;
        for (int i = 0; i < LOG2N; i++) begin
            v[i] = a[LOG2N-1-i];
        end
        return v;
    endfunction

    assign w_abort     = rst | clear;
    assign w_in_fire   = in_valid  & (r_state == c_ST_LOAD);
    assign w_out_fire  = out_ready & (r_state == c_ST_UNLOAD);
    assign w_exec      = (r_state == c_ST_CALC) & r_exec;
    assign w_calc_last = w_exec & (r_bfly == c_BF_ONES) & (r_stage == c_STAGE_LAST);

    // Butterfly addressing: k = j mod 2^s, top = (j>>s)*2^(s+1) + k, bot = top + 2^s
    assign w_k       = r_bfly & ~(c_BF_ONES << r_stage);
    assign w_top     = (({1'b0, r_bfly} >> r_stage) << r_stage << 1) | {1'b0, w_k};
    assign w_half    = c_ONE << r_stage;
    assign w_bot     = w_top | w_half;
    assign w_tw_sh   = c_STAGE_LAST - r_stage;
    assign w_tw_addr = w_k << w_tw_sh;

    assign w_a_re = r_mem_re[w_top];
    assign w_a_im = r_mem_im[w_top];
    assign w_b_re = r_mem_re[w_bot];
    assign w_b_im = r_mem_im[w_bot];

    // Inverse transform uses the conjugate twiddle; no 1/N scaling
    assign w_br     = c_PW'(w_b_re);
    assign w_bi     = c_PW'(w_b_im);
    assign w_wr     = c_PW'(tw_re);
    assign w_wi_raw = c_PW'(tw_im);
    assign w_wi     = r_inv ? -w_wi_raw : w_wi_raw;

    assign w_pr   = w_br * w_wr - w_bi * w_wi;
    assign w_pi   = w_br * w_wi + w_bi * w_wr;
    assign w_t_re = c_W'(w_pr >>> (TBW - 2));
    assign w_t_im = c_W'(w_pi >>> (TBW - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        tw_addr     = '0;
        dout_re     = '0;
        dout_im     = '0;
        case (r_state)
            c_ST_LOAD: begin
                in_ready = 1'b1;
                if (w_in_fire && (r_load_cnt == c_CNT_LAST)) begin
                    w_state_nxt = c_ST_CALC;
                end
            end
            c_ST_CALC: begin
                busy    = 1'b1;
                tw_addr = w_tw_addr;
                if (w_calc_last) begin
                    w_state_nxt = c_ST_UNLOAD;
                end
            end
            c_ST_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (r_out_cnt == c_CNT_LAST);
                dout_re   = r_mem_re[r_out_cnt];
                dout_im   = r_mem_im[r_out_cnt];
                if (w_out_fire && (r_out_cnt == c_CNT_LAST)) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = c_ST_LOAD;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = c_ST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_load_cnt <= '0;
            r_out_cnt  <= '0;
            r_bfly     <= '0;
            r_stage    <= '0;
            r_exec     <= 1'b0;
            r_inv      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_in_fire) begin
                        if (r_load_cnt == '0) begin
                            r_inv <= inverse;
                        end
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                c_ST_CALC: begin
                    r_exec <= ~r_exec;
                    if (r_exec) begin
                        if (r_bfly == c_BF_ONES) begin
                            r_bfly  <= '0;
                            r_stage <= (r_stage == c_STAGE_LAST) ? '0 : r_stage + 1'b1;
                        end else begin
                            r_bfly <= r_bfly + 1'b1;
                        end
                    end
                end
                c_ST_UNLOAD: begin
                    if (w_out_fire) begin
                        r_out_cnt <= r_out_cnt + 1'b1;
                    end
                end
                default: begin
                    r_exec <= 1'b0;
                end
            endcase
        end
    end

    // Sample storage; contents after an abort are don't-care, so no reset
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem_re[f_bitrev(r_load_cnt)] <= c_W'(din_re);
            r_mem_im[f_bitrev(r_load_cnt)] <= c_W'(din_im);
        end else if (w_exec) begin
            r_mem_re[w_top] <= w_a_re + w_t_re;
            r_mem_im[w_top] <= w_a_im + w_t_im;
            r_mem_re[w_bot] <= w_a_re - w_t_re;
            r_mem_im[w_bot] <= w_a_im - w_t_im;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fft_seq                                                |
// | Brief    : table-driven, scoreboarded bench for fft_seq (N=8)        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_fft_seq;

    localparam int DBW   = 8;
    localparam int LOG2N = 3;
    localparam int TBW   = 4;
    localparam int N     = 8;
    localparam int W     = 12;
    localparam int NVEC  = 10;

    logic                  clk;
    logic                  rst;
    logic                  clear;
    logic                  inverse;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DBW-1:0] din_re;
    logic signed [DBW-1:0] din_im;
    logic [LOG2N-2:0]      tw_addr;
    logic signed [TBW-1:0] tw_re;
    logic signed [TBW-1:0] tw_im;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [W-1:0]   dout_re;
    logic signed [W-1:0]   dout_im;
    logic                  out_last;
    logic                  busy;

    fft_seq #(.DBW(DBW), .LOG2N(LOG2N), .TBW(TBW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .inverse(inverse),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_re(din_re), .din_im(din_im),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_re(dout_re), .dout_im(dout_im),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Twiddle ROM, one-cycle latency: W0=(4,0) W1=(3,-3) W2=(0,-4) W3=(-3,-3)
    always_ff @(posedge clk) begin
        case (tw_addr)
            2'd0:    begin tw_re <= 4'sd4;  tw_im <= 4'sd0;  end
            2'd1:    begin tw_re <= 4'sd3;  tw_im <= -4'sd3; end
            2'd2:    begin tw_re <= 4'sd0;  tw_im <= -4'sd4; end
            default: begin tw_re <= -4'sd3; tw_im <= -4'sd3; end
        endcase
    end

    typedef struct packed {
        logic               inv;
        logic [N-1:0][7:0]  xr;
        logic [N-1:0][7:0]  xi;
        logic [N-1:0][15:0] er;
        logic [N-1:0][15:0] ei;
    } vec_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               last;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_cmp;
    int   n_fail;
    bit   stall_mode;
    bit   gap_mode;

    int mode_re [4] = '{4, 0, -4, 0};
    int mode_im [4] = '{0, -4, 0, 4};
    int twr     [4] = '{4, 3, 0, -3};
    int twi     [4] = '{0, -3, -4, -3};
    int flr_re  [4] = '{1, 0, 0, -1};
    int flr_im  [4] = '{0, -1, -1, -1};

    task automatic monitor();
        exp_t e;
        logic signed [31:0] ar, ai, xr, xi;
        if (busy === 1'b1 || out_valid === 1'b1) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL in_ready_blocked: got %b want 0 (busy=%b out_valid=%b)", in_ready, busy, out_valid);
            end
        end
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_bin: got (%0d,%0d) but no bin expected", dout_re, dout_im);
            end else begin
                e  = sb[0];
                ar = dout_re;
                ai = dout_im;
                xr = $signed(e.re);
                xi = $signed(e.im);
                if (ar !== xr || ai !== xi || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL bin: got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)", ar, ai, out_last, xr, xi, e.last);
                end
                if (out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            tw_addr !== '0 || dout_re !== '0 || dout_im !== '0) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b vld=%b last=%b busy=%b tw=%0d dout=(%0d,%0d) want 1 0 0 0 0 (0,0)",
                     name, in_ready, out_valid, out_last, busy, tw_addr, dout_re, dout_im);
        end
    endtask

    task automatic send_frame(input vec_t v, input bit push);
        exp_t e;
        bit   ok;
        int   n;
        if (push) begin
            for (int i = 0; i < N; i++) begin
                e.re   = v.er[i];
                e.im   = v.ei[i];
                e.last = (i == N - 1);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (gap_mode) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            din_re   = v.xr[i];
            din_im   = v.xi[i];
            inverse  = (i == 0) ? v.inv : ~v.inv;
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 200) begin
                ok = in_ready;
                tick();
                n++;
            end
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL load_timeout: sample %0d not accepted after %0d cycles", i, n);
            end
        end
        in_valid = 1'b0;
        din_re   = '0;
        din_im   = '0;
    endtask

    task automatic measure_latency();
        int n;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_load: got %b want 1", busy);
        end
        // Stray samples during CALC must be ignored
        in_valid = 1'b1;
        din_re   = 8'sh55;
        din_im   = -8'sh22;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        din_re   = '0;
        din_im   = '0;
        n_cmp++;
        if (n != N * LOG2N) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want %0d", n, N * LOG2N);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bins left want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int  n;
        bit  saw;
        n_cmp = 0;
        n_fail = 0;
        stall_mode = 1'b0;
        gap_mode = 1'b0;
        rst = 1'b1;
        clear = 1'b0;
        inverse = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        din_re = '0;
        din_im = '0;

        for (int k = 0; k < NVEC; k++) vecs[k] = '0;
        vecs[0].xr[0] = 8'd1;
        for (int i = 0; i < N; i++) vecs[0].er[i] = 16'd1;
        for (int i = 0; i < N; i++) vecs[1].xr[i] = 8'd1;
        vecs[1].er[0] = 16'd8;
        for (int i = 0; i < N; i++) vecs[2].xr[i] = (i % 2 == 0) ? 8'd1 : 8'hFF;
        vecs[2].er[4] = 16'd8;
        vecs[3] = vecs[2];
        vecs[3].inv = 1'b1;
        vecs[4].xr[2] = 8'd4;
        vecs[5].xr[2] = 8'd4;
        vecs[5].inv = 1'b1;
        for (int i = 0; i < N; i++) begin
            vecs[4].er[i] = 16'(mode_re[i % 4]);
            vecs[4].ei[i] = 16'(mode_im[i % 4]);
            vecs[5].er[i] = 16'(mode_re[i % 4]);
            vecs[5].ei[i] = 16'(-mode_im[i % 4]);
        end
        vecs[6].xr[1] = 8'd4;
        vecs[7].xr[1] = 8'd4;
        vecs[7].inv = 1'b1;
        vecs[8].xr[1] = 8'd1;
        for (int j = 0; j < 4; j++) begin
            vecs[6].er[j] = 16'(twr[j]);     vecs[6].ei[j] = 16'(twi[j]);
            vecs[6].er[j+4] = 16'(-twr[j]);  vecs[6].ei[j+4] = 16'(-twi[j]);
            vecs[7].er[j] = 16'(twr[j]);     vecs[7].ei[j] = 16'(-twi[j]);
            vecs[7].er[j+4] = 16'(-twr[j]);  vecs[7].ei[j+4] = 16'(twi[j]);
            vecs[8].er[j] = 16'(flr_re[j]);  vecs[8].ei[j] = 16'(flr_im[j]);
            vecs[8].er[j+4] = 16'(-flr_re[j]); vecs[8].ei[j+4] = 16'(-flr_im[j]);
        end
        vecs[9].xi[0] = 8'd3;
        vecs[9].inv = 1'b1;
        for (int i = 0; i < N; i++) vecs[9].ei[i] = 16'd3;

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;
        tick();

        // Unstalled pass with latency check per frame
        for (int k = 0; k < NVEC; k++) begin
            send_frame(vecs[k], 1'b1);
            measure_latency();
            drain();
        end

        // Backpressure pass: gapped input, random out_ready
        stall_mode = 1'b1;
        gap_mode = 1'b1;
        for (int k = 0; k < NVEC; k++) begin
            send_frame(vecs[k], 1'b1);
            drain();
        end
        stall_mode = 1'b0;
        gap_mode = 1'b0;
        tick();

        // clear at CALC cycle 10 discards the frame
        send_frame(vecs[3], 1'b0);
        repeat (10) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_idle("clear_abort");
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) saw = 1'b1;
        end
        n_cmp++;
        if (saw) begin
            n_fail++;
            $display("FAIL clear_no_output: got out_valid=1 want 0");
        end
        send_frame(vecs[0], 1'b1);
        drain();

        // rst mid-UNLOAD
        send_frame(vecs[4], 1'b1);
        n = 0;
        while (sb.size() > 5 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unload_timeout: got %0d bins left want 5", sb.size());
        end
        rst = 1'b1;
        tick();
        check_idle("rst_unload");
        rst = 1'b0;
        sb.delete();
        tick();
        send_frame(vecs[6], 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
